// File: rtl/rr_mux_arbiter.sv
// Four-source round-robin arbiter feeding a registered 4:1 mux with a
// valid/ready output stage; grants are one-hot strobes that consume source data.
module rr_mux_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [1:0] in0,
  input  logic [1:0] in1,
  input  logic [1:0] in2,
  input  logic [1:0] in3,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic [1:0] out,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int NUM_SRC = 4;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t                      state_q, state_d;
  logic [1:0]                  ptr_q, ptr_d;
  logic [1:0]                  out_q, out_d;
  logic [1:0]                  sel_q, sel_d;
  logic [NUM_SRC-1:0][1:0]     src_data;
  logic [NUM_SRC-1:0]          req_rot;
  logic [1:0]                  off;
  logic [1:0]                  win;
  logic                        accept;
  logic                        take;

  assign src_data = {in3, in2, in1, in0};

  // Rotate requests so bit 0 is the source currently at the head of priority.
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_rot
    logic [1:0] idx;
    assign idx        = ptr_q + 2'(k);
    assign req_rot[k] = req[idx];
  end

  always_comb begin
    off = 2'd0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req_rot[k]) off = 2'(k);
    end
  end

  assign win    = ptr_q + off;
  assign accept = (state_q == IDLE) || out_ready;
  assign take   = accept && (req != 4'b0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = HOLD;
      HOLD:    if (out_ready && !take) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant is forced low during reset so a source never sees a consumption
  // strobe while the capture register is being cleared.
  always_comb begin
    grant     = 4'b0000;
    out_valid = (state_q == HOLD);
    if (!rst && take) grant[win] = 1'b1;
  end

  always_comb begin
    out_d = out_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    if (take) begin
      out_d = src_data[win];
      sel_d = win;
      ptr_d = win + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= 2'b00;
      sel_q <= 2'b00;
      ptr_q <= 2'b00;
    end else begin
      out_q <= out_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
    end
  end

  assign out    = out_q;
  assign select = sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed plus randomized checks of rr_mux_arbiter against a transaction-level
// model of the round-robin search and the output hold register.
module tb_rr_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [1:0] in0, in1, in2, in3;
  logic [3:0] grant;
  logic [1:0] select;
  logic [1:0] out;
  logic       out_valid;
  logic       out_ready;

  int checks   = 0;
  int failures = 0;

  logic [1:0] d [4];
  bit         m_valid;
  logic [1:0] m_out;
  logic [1:0] m_sel;
  int         m_ptr;

  rr_mux_arbiter dut (
    .clk(clk), .rst(rst), .req(req),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .grant(grant), .select(select), .out(out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_grant();
    int w;
    exp_grant = 4'b0000;
    if (rst) return exp_grant;
    if (m_valid && !out_ready) return exp_grant;
    w = winner(req, m_ptr);
    if (w >= 0) exp_grant[w] = 1'b1;
  endfunction

  task automatic set_data(input logic [1:0] a, b, c, e);
    d[0] = a; d[1] = b; d[2] = c; d[3] = e;
    in0 = a; in1 = b; in2 = c; in3 = e;
  endtask

  task automatic model_reset();
    m_valid = 0; m_out = 2'b00; m_sel = 2'b00; m_ptr = 0;
  endtask

  // Apply inputs just after an edge, then compare everything observable before the next edge.
  task automatic drive(input string tag, input logic [3:0] r, input logic rdy);
    req = r; out_ready = rdy;
    #1;
    chk({tag, ".grant"}, {4'b0, grant}, {4'b0, exp_grant()});
    chk({tag, ".valid"}, {7'b0, out_valid}, {7'b0, m_valid});
    chk({tag, ".out"}, {6'b0, out}, {6'b0, m_out});
    chk({tag, ".sel"}, {6'b0, select}, {6'b0, m_sel});
  endtask

  task automatic tick();
    int w;
    @(posedge clk);
    if (rst) model_reset();
    else if (!m_valid || out_ready) begin
      w = winner(req, m_ptr);
      if (w >= 0) begin
        m_out = d[w]; m_sel = 2'(w); m_ptr = (w + 1) % 4; m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic step(input string tag, input logic [3:0] r, input logic rdy);
    drive(tag, r, rdy);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0; out_ready = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst.valid", {7'b0, out_valid}, 8'h00);
    chk("rst.out", {6'b0, out}, 8'h00);
    chk("rst.sel", {6'b0, select}, 8'h00);
    chk("rst.grant", {4'b0, grant}, 8'h00);
    rst = 1'b0;
  endtask

  initial begin
    set_data(2'b00, 2'b00, 2'b00, 2'b00);
    model_reset();
    do_reset();

    // Single request from source 2.
    set_data(2'b00, 2'b00, 2'b10, 2'b00);
    drive("single", 4'b0100, 1'b1);
    chk("single.g0", {4'b0, grant}, 8'h04);
    tick();
    chk("single.out", {6'b0, out}, 8'h02);
    chk("single.sel", {6'b0, select}, 8'h02);
    chk("single.v", {7'b0, out_valid}, 8'h01);
    step("drain0", 4'b0000, 1'b1);

    // Rotation with all four requesting, from fresh reset priority.
    do_reset();
    set_data(2'b00, 2'b01, 2'b10, 2'b11);
    for (int i = 0; i < 8; i++) begin
      step("rot", 4'b1111, 1'b1);
      chk("rot.sel", {6'b0, select}, 8'(i % 4));
      chk("rot.out", {6'b0, out}, 8'(i % 4));
    end

    // Backpressure: get select=1 then stall three cycles.
    step("bp.pre", 4'b1111, 1'b1);
    step("bp.pre", 4'b1111, 1'b1);
    chk("bp.sel1", {6'b0, select}, 8'h01);
    for (int i = 0; i < 3; i++) begin
      drive("bp.stall", 4'b1111, 1'b0);
      chk("bp.g0", {4'b0, grant}, 8'h00);
      tick();
      chk("bp.hold", {6'b0, select}, 8'h01);
    end
    drive("bp.go", 4'b1111, 1'b1);
    chk("bp.g2", {4'b0, grant}, 8'h04);
    tick();

    // Wrap: win by 2 leaves ptr=3; then 0,1 from req=0011.
    step("wrap.a", 4'b0100, 1'b1);
    step("wrap.b", 4'b0011, 1'b1);
    chk("wrap.w0", {6'b0, select}, 8'h00);
    step("wrap.c", 4'b0011, 1'b1);
    chk("wrap.w1", {6'b0, select}, 8'h01);
    do_reset();
    step("skip.a", 4'b1000, 1'b1);
    chk("skip.w3", {6'b0, select}, 8'h03);
    step("skip.b", 4'b1111, 1'b1);
    chk("skip.ptr0", {6'b0, select}, 8'h00);

    // Drain keeps out/select; out_valid drops.
    step("drain", 4'b0000, 1'b1);
    chk("drain.v", {7'b0, out_valid}, 8'h00);
    chk("drain.out", {6'b0, out}, {6'b0, d[0]});

    // Asynchronous reset in the middle of HOLD.
    set_data(2'b11, 2'b11, 2'b11, 2'b11);
    step("ar.pre", 4'b0010, 1'b0);
    chk("ar.held", {6'b0, out}, 8'h03);
    req = 4'b1111; out_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("ar.valid", {7'b0, out_valid}, 8'h00);
    chk("ar.out", {6'b0, out}, 8'h00);
    chk("ar.sel", {6'b0, select}, 8'h00);
    chk("ar.grant", {4'b0, grant}, 8'h00);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      set_data(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
      step("rand", 4'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 The block SHALL have one clock and one asynchronous, active-high reset.
REQ-002 The clock and reset ports SHALL be, one per line:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
REQ-003 The request and data ports SHALL be, one per line:
- req  input  4  request per source; bit i = source i
- in0..in3  input  2 each  source data; held stable while req[i]=1
REQ-004 The handshake and output ports SHALL be, one per line:
- grant  output  4  one-hot acceptance strobe to sources; combinational
- select  output  2  index of the source in the output register; feeds the 4:1 mux select
- out  output  2  registered data of the granted source
- out_valid  output  1  out/select hold a valid item
- out_ready  input  1  downstream accepts out this cycle
REQ-005 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-006 The block SHALL have two states: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-007 The block SHALL open an accept window when state=IDLE, or when state=HOLD and out_ready=1.
REQ-008 In an accept window with req!=0, the block SHALL choose a winner w by searching req from ptr upward with wrap (ptr, ptr+1, ... mod 4).
REQ-009 In the same accept window it SHALL assert grant[w]=1, with all other grant bits 0.
REQ-010 At the next rising edge it SHALL capture out<=in_w, select<=w, ptr<=(w+1) mod 4, and state<=HOLD.
REQ-011 grant SHALL be 0 in every cycle that is not an accept window, and in every accept window with req=0.
REQ-012 A source SHALL treat grant[i]=1 at a rising edge as consumption of its current data.
REQ-013 In HOLD with out_ready=1 and req=0, the block SHALL go to IDLE at the next edge.
REQ-014 In that case out and select SHALL retain their last values, out_valid SHALL go to 0, and ptr SHALL be unchanged.
REQ-015 In HOLD with out_ready=0, out, select, out_valid, ptr and state SHALL all hold.
REQ-016 Back-to-back throughput: in HOLD with out_ready=1 and req!=0, the next item SHALL be captured at the same edge, so out_valid stays 1 and there is no bubble.
REQ-017 Latency from req rising in IDLE to out_valid=1 SHALL be one clock.
REQ-018 The pointer SHALL wrap: a win by source 3 sets ptr=0.
REQ-019 Fairness: with all four requests held high, grants SHALL rotate 0,1,2,3,0,... with one grant per accepted item.
REQ-020 A request that drops before it is granted SHALL be ignored without error; the search uses only the current cycle's req.
REQ-021 When out_ready and a new req arrive simultaneously in HOLD, the new item SHALL replace the old at that edge.
REQ-022 select SHALL always equal the index of the source whose data is in out.

Reset
REQ-023 While rst=1, asynchronously: state=IDLE, out=2'b00, select=2'b00, out_valid=0, ptr=0, and grant=4'b0000 (forced).
REQ-024 If rst asserts mid-HOLD, the pending item SHALL be discarded and no grant SHALL be issued.
REQ-025 The first accept window SHALL be the first cycle with rst=0.
REQ-026 After reset deassertion, priority SHALL start at source 0.

Verification
REQ-027 Single request: reset, in2=2'b10, req=4'b0100, out_ready=1 -> grant=4'b0100 in the first cycle; next edge gives out=2'b10, select=2, out_valid=1.
REQ-028 Rotation: in0..in3=00,01,10,11, req=4'b1111, out_ready=1 for 8 cycles -> select sequence 0,1,2,3,0,1,2,3 with out matching; out_valid stays 1; one grant bit per cycle.
REQ-029 Backpressure: in HOLD with select=1, drop out_ready to 0 for 3 cycles with req=4'b1111 -> grant=0, and out/select frozen for those 3 cycles; on out_ready=1, grant=4'b0100.
REQ-030 Wrap and skip: ptr=3 with req=4'b0011 -> winner 0, then winner 1; with req=4'b1000 and ptr=0 -> winner 3, then ptr=0.
REQ-031 Drain and reset: in HOLD, set req=0 and out_ready=1 -> next edge out_valid=0 with out held; separately, assert rst mid-HOLD -> out_valid=0, out=00, select=0 immediately, without waiting for a clock edge.
REQ-032 For every accepted item, out SHALL equal the 4:1 mux function of in0..in3 at select; the bench compares against an independent model.
